// File: rtl/spi_slave_if.sv
// Fabric-side handshake bundle for spi_slave.
// slave modport: the SPI responder; master modport: the fabric logic it talks to.
`timescale 1ns/1ps
interface spi_slave_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic [WIDTH-1:0] rx_data;
  logic             rx_strobe;
  logic             rx_accept;
  logic             tx_request;
  logic [WIDTH-1:0] tx_data;
  logic             tx_strobe;
  logic             busy;
  logic             rx_overrun;
  logic             tx_underrun;

  modport slave (
    output rx_data, rx_strobe, tx_request, busy, rx_overrun, tx_underrun,
    input  rx_accept, tx_data, tx_strobe
  );

  modport master (
    input  rx_data, rx_strobe, tx_request, busy, rx_overrun, tx_underrun,
    output rx_accept, tx_data, tx_strobe
  );
endinterface

// File: rtl/spi_slave.sv
// SPI mode-0 responder, MSB first, oversampled in the mclk domain.
// Optional feature macro: SPI_SLAVE_LOOPBACK_EN -- on an underrun load, echo the most
// recently completed rx word instead of IDLE_FILL.
`timescale 1ns/1ps
module spi_slave #(
  parameter int unsigned      WIDTH       = 16,
  parameter logic [WIDTH-1:0] IDLE_FILL   = {WIDTH{1'b1}},
  parameter int unsigned      SYNC_STAGES = 2
) (
  input  logic       mclk,
  input  logic       reset,
  input  logic       ss,
  input  logic       sck,
  input  logic       mosi,
  output logic       miso,
  spi_slave_if.slave bus
);

  localparam int unsigned     CntW    = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] ss_sync_q, sck_sync_q, mosi_sync_q;
  logic                   ss_prev_q, sck_prev_q;
  logic                   ss_s, sck_s, mosi_s;
  logic                   ss_fall, ss_rise, sck_rise, sck_fall;

  logic [CntW-1:0]  count_q, count_d;
  logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_strobe_q, rx_strobe_d;
  logic             rx_overrun_q, rx_overrun_d;
  logic             tx_underrun_q, tx_underrun_d;
  logic             miso_q, miso_d;
  logic [WIDTH-1:0] rx_word;
  logic             do_load;

  // Pin synchronisers plus one-flop edge detectors; ss idles high so reset it that way.
  always_ff @(posedge mclk) begin
    if (reset) begin
      ss_sync_q   <= '1;
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      ss_prev_q   <= 1'b1;
      sck_prev_q  <= 1'b0;
    end else begin
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss};
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      ss_prev_q   <= ss_s;
      sck_prev_q  <= sck_s;
    end
  end

  assign ss_s     = ss_sync_q[SYNC_STAGES-1];
  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign ss_fall  = ss_prev_q & ~ss_s;
  assign ss_rise  = ~ss_prev_q & ss_s;
  assign sck_rise = ~sck_prev_q & sck_s;
  assign sck_fall = sck_prev_q & ~sck_s;

  // FSM state register.
  always_ff @(posedge mclk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next state, shifters, handshakes; a completion beats a same-cycle rx_accept.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    rx_shift_d    = rx_shift_q;
    tx_shift_d    = tx_shift_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    rx_data_d     = rx_data_q;
    rx_strobe_d   = rx_strobe_q;
    rx_overrun_d  = 1'b0;
    tx_underrun_d = 1'b0;
    do_load       = 1'b0;
    rx_word       = {rx_shift_q[WIDTH-2:0], mosi_s};

    if (bus.rx_accept) rx_strobe_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ss_fall) begin
          state_d = StActive;
          do_load = 1'b1;
        end
      end
      StActive: begin
        if (ss_rise) begin
          // Partial word is discarded; holding register is left alone.
          state_d    = StIdle;
          count_d    = '0;
          rx_shift_d = '0;
        end else if (sck_rise) begin
          rx_shift_d = rx_word;
          if (count_q == LastCnt) begin
            count_d      = '0;
            rx_data_d    = rx_word;
            rx_strobe_d  = 1'b1;
            rx_overrun_d = rx_strobe_q & ~bus.rx_accept;
            do_load      = 1'b1;
          end else begin
            count_d = count_q + CntW'(1);
          end
        end else if (sck_fall && count_q != '0) begin
          // At count 0 the freshly loaded MSB is already on miso.
          tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
        end
      end
      default: state_d = StIdle;
    endcase

    if (do_load) begin
      if (hold_full_q) begin
        tx_shift_d  = hold_q;
        hold_full_d = 1'b0;
      end else begin
`ifdef SPI_SLAVE_LOOPBACK_EN
        tx_shift_d    = rx_data_d;
`else
        tx_shift_d    = IDLE_FILL;
`endif
        tx_underrun_d = 1'b1;
      end
    end

    // Only accepted when the holding register was empty at the start of the cycle.
    if (bus.tx_strobe && !hold_full_q) begin
      hold_d      = bus.tx_data;
      hold_full_d = 1'b1;
    end

    miso_d = (state_d == StActive) & tx_shift_d[WIDTH-1];
  end

  // Datapath and output registers.
  always_ff @(posedge mclk) begin
    if (reset) begin
      count_q       <= '0;
      rx_shift_q    <= '0;
      tx_shift_q    <= '0;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      rx_data_q     <= '0;
      rx_strobe_q   <= 1'b0;
      rx_overrun_q  <= 1'b0;
      tx_underrun_q <= 1'b0;
      miso_q        <= 1'b0;
    end else begin
      count_q       <= count_d;
      rx_shift_q    <= rx_shift_d;
      tx_shift_q    <= tx_shift_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      rx_data_q     <= rx_data_d;
      rx_strobe_q   <= rx_strobe_d;
      rx_overrun_q  <= rx_overrun_d;
      tx_underrun_q <= tx_underrun_d;
      miso_q        <= miso_d;
    end
  end

  assign miso            = miso_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_strobe   = rx_strobe_q;
  assign bus.tx_request  = ~hold_full_q;
  assign bus.busy        = (state_q == StActive);
  assign bus.rx_overrun  = rx_overrun_q;
  assign bus.tx_underrun = tx_underrun_q;

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: an SPI master model drives the pins, a reference model
// pushes expected rx words, miso words and pulse counts, and a monitor checks them.
`timescale 1ns/1ps
module tb_spi_slave;
  localparam int unsigned W    = 16;
  localparam int          HALF = 8;  // sck half period in mclk cycles

  logic mclk = 1'b0, reset = 1'b1, ss = 1'b1, sck = 1'b0, mosi = 1'b0;
  logic miso;

  spi_slave_if #(.WIDTH(W)) bus ();

  spi_slave #(
    .WIDTH      (W),
    .IDLE_FILL  (16'hFFFF),
    .SYNC_STAGES(2)
  ) dut (
    .mclk(mclk),
    .reset(reset),
    .ss  (ss),
    .sck (sck),
    .mosi(mosi),
    .miso(miso),
    .bus (bus)
  );

  always #5 mclk = ~mclk;

  int n_checks = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model state.
  logic [W-1:0] pend[$];
  logic [W-1:0] exp_rx[$], exp_tx[$], got_tx[$];
  logic [W-1:0] mo_words[$];
  logic [W-1:0] last_rx = '0;
  int  exp_und = 0, exp_ovr = 0, seen_und = 0, seen_ovr = 0;
  bit  rx_pending = 0, auto_acc = 1, acc_req = 0;
  longint cyc = 0, last_rise = 0;
  logic prev_strobe = 1'b0, prev_acc = 1'b0;

  // Word the responder will shift out next; consumes the holding word if any.
  function automatic logic [W-1:0] model_load();
    if (pend.size() > 0) return pend.pop_front();
    exp_und++;
`ifdef SPI_SLAVE_LOOPBACK_EN
    return last_rx;
`else
    return 16'hFFFF;
`endif
  endfunction

  function automatic void model_complete(input logic [W-1:0] word, input bit acc_same);
    exp_rx.push_back(word);
    last_rx = word;
    if (rx_pending && !acc_same) exp_ovr++;
    rx_pending = !auto_acc;
  endfunction

  always @(posedge mclk) cyc <= cyc + 1;

  // Fabric side: optional auto-accept, or a single requested accept pulse.
  initial begin
    bus.rx_accept = 1'b0;
    forever begin
      @(posedge mclk);
      #1;
      if (acc_req) begin
        bus.rx_accept = 1'b1;
        acc_req = 0;
      end else begin
        bus.rx_accept = auto_acc && bus.rx_strobe;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a word or the master reads one.
  always @(negedge mclk) begin
    if (!reset) begin
      if (bus.tx_underrun) seen_und++;
      if (bus.rx_overrun) seen_ovr++;
      if (bus.rx_strobe && (!prev_strobe || bus.rx_overrun || prev_acc)) begin
        if (exp_rx.size() == 0) check("rx_unexpected", 32'(bus.rx_data), 32'hFFFF_FFFF);
        else check("rx_data", 32'(bus.rx_data), 32'(exp_rx.pop_front()));
        check("rx_latency", 32'((cyc - last_rise) inside {[3:4]}), 32'd1);
      end
      while (got_tx.size() > 0) begin
        if (exp_tx.size() == 0) check("miso_unexpected", 32'(got_tx.pop_front()), 32'hFFFF_FFFF);
        else check("miso_word", 32'(got_tx.pop_front()), 32'(exp_tx.pop_front()));
      end
    end
    prev_strobe = bus.rx_strobe;
    prev_acc    = bus.rx_accept;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge mclk);
    #1;
  endtask

  task automatic xfer_bits(input logic [W-1:0] mo, input int nbits, input bit acc_last,
                           output logic [W-1:0] mi);
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[W-1-i];
      wait_clk(HALF);
      sck = 1'b1;
      mi = {mi[W-2:0], miso};
      last_rise = cyc;
      if (acc_last && i == int'(W) - 1) begin
        fork
          begin
            @(posedge mclk);
            #2;
            acc_req = 1;
          end
        join_none
      end
      wait_clk(HALF);
      sck = 1'b0;
    end
  endtask

  task automatic frame(input int nfull, input int partial, input bit acc_last);
    logic [W-1:0] mo, mi, ld;
    ss = 1'b0;
    ld = model_load();
    if (nfull > 0) exp_tx.push_back(ld);
    wait_clk(HALF);
    check("busy", 32'(bus.busy), 32'd1);
    for (int w = 0; w < nfull; w++) begin
      mo = (mo_words.size() > 0) ? mo_words.pop_front() : W'($urandom);
      model_complete(mo, acc_last && w == nfull - 1);
      ld = model_load();
      if (w < nfull - 1) exp_tx.push_back(ld);
      xfer_bits(mo, W, acc_last && w == nfull - 1, mi);
      got_tx.push_back(mi);
    end
    if (partial > 0) xfer_bits(W'($urandom), partial, 1'b0, mi);
    wait_clk(HALF);
    ss = 1'b1;
    wait_clk(2 * HALF);
  endtask

  task automatic tx_push(input logic [W-1:0] d);
    bus.tx_data   = d;
    bus.tx_strobe = 1'b1;
    wait_clk(1);
    bus.tx_strobe = 1'b0;
    if (pend.size() == 0) pend.push_back(d);
    wait_clk(1);
    check("tx_request", 32'(bus.tx_request), 32'(pend.size() == 0));
  endtask

  initial begin
    logic [W-1:0] mi;
    bus.tx_strobe = 1'b0;
    bus.tx_data   = '0;
    wait_clk(3);
    check("rst_miso", 32'(miso), 32'd0);
    check("rst_rx_data", 32'(bus.rx_data), 32'd0);
    check("rst_rx_strobe", 32'(bus.rx_strobe), 32'd0);
    check("rst_tx_request", 32'(bus.tx_request), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_rx_overrun", 32'(bus.rx_overrun), 32'd0);
    check("rst_tx_underrun", 32'(bus.tx_underrun), 32'd0);
    reset = 1'b0;
    wait_clk(2);

    // No tx word: fill is sent, underrun at frame start and after the word.
    mo_words.push_back(16'hA5C3);
    frame(1, 0, 0);
    check("underrun_cnt_a", 32'(seen_und), 32'(exp_und));

    // Holding word, ignored second strobe, then two back-to-back words.
    tx_push(16'h1234);
    tx_push(16'h5555);
    frame(2, 0, 0);
    check("tx_request_after", 32'(bus.tx_request), 32'd1);

    // No accepts: second word overruns.
    auto_acc = 0;
    frame(2, 0, 0);
    check("overrun_cnt_a", 32'(seen_ovr), 32'(exp_ovr));
    check("strobe_held", 32'(bus.rx_strobe), 32'd1);

    // Accept lands in the completion cycle: no overrun, strobe kept.
    frame(1, 0, 1);
    check("overrun_cnt_b", 32'(seen_ovr), 32'(exp_ovr));
    check("strobe_same_cycle", 32'(bus.rx_strobe), 32'd1);
    auto_acc   = 1;
    rx_pending = 0;
    wait_clk(4);
    check("strobe_cleared", 32'(bus.rx_strobe), 32'd0);

    // Aborted word after 9 rises, then a clean word.
    frame(0, 9, 0);
    mo_words.push_back(16'h00FF);
    frame(1, 0, 0);
    check("rx_after_abort", 32'(bus.rx_data), 32'h00FF);

`ifdef SPI_SLAVE_LOOPBACK_EN
    mo_words.push_back(16'hBEEF);
    mo_words.push_back(W'($urandom));
    frame(2, 0, 0);
    check("underrun_cnt_lb", 32'(seen_und), 32'(exp_und));
`endif

    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(0, 1) == 1) tx_push(W'($urandom));
      frame(int'($urandom_range(1, 3)),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : 0, 0);
    end
    check("underrun_cnt_r", 32'(seen_und), 32'(exp_und));
    check("overrun_cnt_r", 32'(seen_ovr), 32'(exp_ovr));

    // Reset in the middle of a word with ss low and a word in the holding register.
    ss = 1'b0;
    void'(model_load());
    wait_clk(HALF);
    tx_push(W'($urandom));
    xfer_bits(W'($urandom), 5, 1'b0, mi);
    reset = 1'b1;
    wait_clk(1);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_miso", 32'(miso), 32'd0);
    check("mid_rst_tx_request", 32'(bus.tx_request), 32'd1);
    check("mid_rst_rx_data", 32'(bus.rx_data), 32'd0);
    check("mid_rst_rx_strobe", 32'(bus.rx_strobe), 32'd0);
    ss  = 1'b1;
    sck = 1'b0;
    pend.delete();
    rx_pending = 0;
    last_rx    = '0;
    wait_clk(3);
    reset = 1'b0;
    wait_clk(4);
    frame(2, 0, 0);

    wait_clk(4);
    check("underrun_cnt_end", 32'(seen_und), 32'(exp_und));
    check("overrun_cnt_end", 32'(seen_ovr), 32'(exp_ovr));
    check("rx_queue_drained", 32'(exp_rx.size()), 32'd0);
    check("tx_queue_drained", 32'(exp_tx.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
